// File: rtl/rd_buf_chunk_req.sv
// Splits one whole-transfer read into bounded chunk requests for the read circular
// buffer tile, snoops the tile's data return for chunk completion and emits a done token.
`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 16
`endif

module rd_buf_chunk_req #(
  parameter int BUF_PTR_W       = 16,
  parameter int XFER_SIZE_W     = 32,
  parameter int MAX_CHUNK       = 1024,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            src_xfer_req_val,
  input  logic [`FLOW_ID_W-1:0]           src_xfer_req_flowid,
  input  logic [BUF_PTR_W-1:0]            src_xfer_req_offset,
  input  logic [XFER_SIZE_W-1:0]          src_xfer_req_size,
  output logic                            xfer_src_req_rdy,
  output logic                            chunk_rd_buf_req_val,
  output logic [`FLOW_ID_W-1:0]           chunk_rd_buf_req_flowid,
  output logic [BUF_PTR_W-1:0]            chunk_rd_buf_req_offset,
  output logic [`MSG_DATA_SIZE_WIDTH-1:0] chunk_rd_buf_req_size,
  input  logic                            rd_buf_chunk_req_rdy,
  input  logic                            mon_rd_buf_data_val,
  input  logic                            mon_rd_buf_data_last,
  input  logic                            mon_rd_buf_data_rdy,
  output logic                            xfer_done_val,
  output logic [`FLOW_ID_W-1:0]           xfer_done_flowid,
  input  logic                            dst_xfer_done_rdy
);

  localparam int FLOW_W = `FLOW_ID_W;
  localparam int MSG_W  = `MSG_DATA_SIZE_WIDTH;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [XFER_SIZE_W-1:0] MAX_CHUNK_X = XFER_SIZE_W'(MAX_CHUNK);
  localparam logic [CNT_W-1:0]       MAX_OUT_C   = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [FLOW_W-1:0]      flowid_q, flowid_d;
  logic [BUF_PTR_W-1:0]   cur_offset_q, cur_offset_d;
  logic [XFER_SIZE_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;

  logic [XFER_SIZE_W-1:0] chunk_sz;
  logic                   issue_hs;
  logic                   cpl;
  logic                   cpl_eff;

  assign chunk_sz = (remaining_q < MAX_CHUNK_X) ? remaining_q : MAX_CHUNK_X;
  assign cpl      = mon_rd_buf_data_val & mon_rd_buf_data_rdy & mon_rd_buf_data_last;
  // A completion with nothing outstanding is a protocol error and is dropped.
  assign cpl_eff  = cpl && (out_cnt_q != '0);

  assign chunk_rd_buf_req_val    = (state_q == ISSUE) && (out_cnt_q < MAX_OUT_C);
  assign issue_hs                = chunk_rd_buf_req_val & rd_buf_chunk_req_rdy;
  assign chunk_rd_buf_req_flowid = chunk_rd_buf_req_val ? flowid_q : '0;
  assign chunk_rd_buf_req_offset = chunk_rd_buf_req_val ? cur_offset_q : '0;
  assign chunk_rd_buf_req_size   = chunk_rd_buf_req_val ? MSG_W'(chunk_sz) : '0;

  assign xfer_done_val    = (state_q == DONE);
  assign xfer_done_flowid = xfer_done_val ? flowid_q : '0;
  assign xfer_src_req_rdy = (state_q == IDLE) && !rst;

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (issue_hs && !cpl_eff) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end else if (!issue_hs && cpl_eff) begin
      out_cnt_d = out_cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    flowid_d     = flowid_q;
    cur_offset_d = cur_offset_q;
    remaining_d  = remaining_q;
    case (state_q)
      IDLE: begin
        if (src_xfer_req_val && xfer_src_req_rdy) begin
          flowid_d     = src_xfer_req_flowid;
          cur_offset_d = src_xfer_req_offset;
          remaining_d  = src_xfer_req_size;
          state_d      = (src_xfer_req_size == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (issue_hs) begin
          cur_offset_d = cur_offset_q + BUF_PTR_W'(chunk_sz);
          remaining_d  = remaining_q - chunk_sz;
          if (remaining_q == chunk_sz) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave once the last outstanding chunk has returned, even if that happens now.
        if ((out_cnt_q == '0) || ((out_cnt_q == CNT_W'(1)) && cpl)) state_d = DONE;
      end
      DONE: begin
        if (dst_xfer_done_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    flowid_q     <= flowid_d;
    cur_offset_q <= cur_offset_d;
    remaining_q  <= remaining_d;
  end

endmodule

// File: tb/tb_rd_buf_chunk_req.sv
// Directed bench for rd_buf_chunk_req: inputs change and outputs are checked on the
// falling clock edge, with hand-computed expected chunk and done values.
module tb_rd_buf_chunk_req;

  logic        clk = 1'b0;
  logic        rst;
  logic        src_xfer_req_val;
  logic [7:0]  src_xfer_req_flowid;
  logic [15:0] src_xfer_req_offset;
  logic [31:0] src_xfer_req_size;
  logic        xfer_src_req_rdy;
  logic        chunk_rd_buf_req_val;
  logic [7:0]  chunk_rd_buf_req_flowid;
  logic [15:0] chunk_rd_buf_req_offset;
  logic [15:0] chunk_rd_buf_req_size;
  logic        rd_buf_chunk_req_rdy;
  logic        mon_rd_buf_data_val;
  logic        mon_rd_buf_data_last;
  logic        mon_rd_buf_data_rdy;
  logic        xfer_done_val;
  logic [7:0]  xfer_done_flowid;
  logic        dst_xfer_done_rdy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rd_buf_chunk_req dut (
    .clk                     (clk),
    .rst                     (rst),
    .src_xfer_req_val        (src_xfer_req_val),
    .src_xfer_req_flowid     (src_xfer_req_flowid),
    .src_xfer_req_offset     (src_xfer_req_offset),
    .src_xfer_req_size       (src_xfer_req_size),
    .xfer_src_req_rdy        (xfer_src_req_rdy),
    .chunk_rd_buf_req_val    (chunk_rd_buf_req_val),
    .chunk_rd_buf_req_flowid (chunk_rd_buf_req_flowid),
    .chunk_rd_buf_req_offset (chunk_rd_buf_req_offset),
    .chunk_rd_buf_req_size   (chunk_rd_buf_req_size),
    .rd_buf_chunk_req_rdy    (rd_buf_chunk_req_rdy),
    .mon_rd_buf_data_val     (mon_rd_buf_data_val),
    .mon_rd_buf_data_last    (mon_rd_buf_data_last),
    .mon_rd_buf_data_rdy     (mon_rd_buf_data_rdy),
    .xfer_done_val           (xfer_done_val),
    .xfer_done_flowid        (xfer_done_flowid),
    .dst_xfer_done_rdy       (dst_xfer_done_rdy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic mon(input logic v);
    mon_rd_buf_data_val  = v;
    mon_rd_buf_data_rdy  = v;
    mon_rd_buf_data_last = v;
  endtask

  task automatic send(input logic [7:0] f, input logic [15:0] o, input logic [31:0] s);
    src_xfer_req_val    = 1'b1;
    src_xfer_req_flowid = f;
    src_xfer_req_offset = o;
    src_xfer_req_size   = s;
    nxt();
    src_xfer_req_val    = 1'b0;
  endtask

  task automatic chunk(input string tag, input logic [15:0] o, input logic [15:0] s);
    chk({tag, "_val"}, 64'(chunk_rd_buf_req_val), 64'd1);
    chk({tag, "_off"}, 64'(chunk_rd_buf_req_offset), 64'(o));
    chk({tag, "_size"}, 64'(chunk_rd_buf_req_size), 64'(s));
  endtask

  task automatic done(input string tag, input logic [7:0] f);
    chk({tag, "_val"}, 64'(xfer_done_val), 64'd1);
    chk({tag, "_flow"}, 64'(xfer_done_flowid), 64'(f));
  endtask

  initial begin
    rst = 1'b1;
    src_xfer_req_val = 1'b0;
    src_xfer_req_flowid = '0;
    src_xfer_req_offset = '0;
    src_xfer_req_size = '0;
    rd_buf_chunk_req_rdy = 1'b1;
    dst_xfer_done_rdy = 1'b1;
    mon(1'b0);

    // Reset state
    nxt();
    chk("rst_xfer_rdy", 64'(xfer_src_req_rdy), 64'd0);
    chk("rst_chunk_val", 64'(chunk_rd_buf_req_val), 64'd0);
    chk("rst_done_val", 64'(xfer_done_val), 64'd0);
    chk("rst_chunk_off", 64'(chunk_rd_buf_req_offset), 64'd0);
    chk("rst_done_flow", 64'(xfer_done_flowid), 64'd0);
    nxt();
    rst = 1'b0;
    nxt();
    chk("post_rst_xfer_rdy", 64'(xfer_src_req_rdy), 64'd1);

    // Basic split: 2500 bytes at 0x0100
    send(8'd3, 16'h0100, 32'd2500);
    chunk("b0", 16'h0100, 16'd1024);
    chk("b0_flow", 64'(chunk_rd_buf_req_flowid), 64'd3);
    nxt();
    chunk("b1", 16'h0500, 16'd1024);
    nxt();
    chunk("b2", 16'h0900, 16'd452);
    nxt();
    chk("b_drain_val", 64'(chunk_rd_buf_req_val), 64'd0);
    chk("b_busy_rdy", 64'(xfer_src_req_rdy), 64'd0);
    mon(1'b1);
    nxt();
    nxt();
    chk("b_early_done", 64'(xfer_done_val), 64'd0);
    nxt();
    mon(1'b0);
    done("b_done", 8'd3);
    nxt();
    chk("b_done_clr", 64'(xfer_done_val), 64'd0);
    chk("b_idle_rdy", 64'(xfer_src_req_rdy), 64'd1);

    // Offset wrap at the 16-bit buffer end
    send(8'd1, 16'hFE00, 32'd2048);
    chunk("w0", 16'hFE00, 16'd1024);
    nxt();
    chunk("w1", 16'h0200, 16'd1024);
    nxt();
    chk("w_drain_val", 64'(chunk_rd_buf_req_val), 64'd0);
    mon(1'b1);
    nxt();
    nxt();
    mon(1'b0);
    done("w_done", 8'd1);
    nxt();

    // Outstanding limit with 8192 bytes and no early returns
    send(8'd2, 16'h0000, 32'd8192);
    chunk("o0", 16'h0000, 16'd1024);
    nxt();
    chunk("o1", 16'h0400, 16'd1024);
    nxt();
    chunk("o2", 16'h0800, 16'd1024);
    nxt();
    chunk("o3", 16'h0C00, 16'd1024);
    nxt();
    chk("o_limit_val0", 64'(chunk_rd_buf_req_val), 64'd0);
    nxt();
    chk("o_limit_val1", 64'(chunk_rd_buf_req_val), 64'd0);
    nxt();
    chk("o_limit_val2", 64'(chunk_rd_buf_req_val), 64'd0);
    chk("o_limit_cnt", 64'(dut.out_cnt_q), 64'd4);
    mon(1'b1);
    nxt();
    mon(1'b0);
    chunk("o4", 16'h1000, 16'd1024);
    nxt();
    chk("o_one_more_only", 64'(chunk_rd_buf_req_val), 64'd0);
    mon(1'b1);
    nxt();
    chunk("o5", 16'h1400, 16'd1024);
    nxt();
    mon(1'b0);
    chk("o_same_cyc_cnt", 64'(dut.out_cnt_q), 64'd3);
    chunk("o6", 16'h1800, 16'd1024);
    nxt();
    chk("o_full_again", 64'(chunk_rd_buf_req_val), 64'd0);
    mon(1'b1);
    nxt();
    chunk("o7", 16'h1C00, 16'd1024);
    nxt();
    chk("o_drain_val", 64'(chunk_rd_buf_req_val), 64'd0);
    nxt();
    nxt();
    chk("o_early_done", 64'(xfer_done_val), 64'd0);
    nxt();
    mon(1'b0);
    done("o_done", 8'd2);
    nxt();

    // Zero-size transfer with the done token held back
    dst_xfer_done_rdy = 1'b0;
    send(8'd7, 16'h1234, 32'd0);
    chk("z_chunk_val", 64'(chunk_rd_buf_req_val), 64'd0);
    done("z_done", 8'd7);
    chk("z_xfer_rdy", 64'(xfer_src_req_rdy), 64'd0);
    nxt();
    chk("z_xfer_rdy_hold", 64'(xfer_src_req_rdy), 64'd0);
    done("z_done_hold", 8'd7);
    dst_xfer_done_rdy = 1'b1;
    nxt();
    chk("z_done_clr", 64'(xfer_done_val), 64'd0);
    chk("z_idle_rdy", 64'(xfer_src_req_rdy), 64'd1);

    // Backpressure on both the chunk and the done interfaces
    rd_buf_chunk_req_rdy = 1'b0;
    dst_xfer_done_rdy = 1'b0;
    send(8'd5, 16'h0010, 32'd300);
    for (int i = 0; i < 6; i++) begin
      chunk($sformatf("bp_hold%0d", i), 16'h0010, 16'd300);
      chk($sformatf("bp_flow%0d", i), 64'(chunk_rd_buf_req_flowid), 64'd5);
      if (i == 5) rd_buf_chunk_req_rdy = 1'b1;
      nxt();
    end
    chk("bp_drain_val", 64'(chunk_rd_buf_req_val), 64'd0);
    mon(1'b1);
    nxt();
    mon(1'b0);
    for (int i = 0; i < 3; i++) begin
      done($sformatf("bp_done%0d", i), 8'd5);
      if (i == 2) dst_xfer_done_rdy = 1'b1;
      nxt();
    end
    chk("bp_done_clr", 64'(xfer_done_val), 64'd0);

    // Reset in the middle of an issuing transfer
    send(8'd9, 16'h2000, 32'd4096);
    chunk("r0", 16'h2000, 16'd1024);
    nxt();
    chunk("r1", 16'h2400, 16'd1024);
    nxt();
    chunk("r2", 16'h2800, 16'd1024);
    rst = 1'b1;
    nxt();
    chk("r_chunk_val", 64'(chunk_rd_buf_req_val), 64'd0);
    chk("r_done_val", 64'(xfer_done_val), 64'd0);
    chk("r_out_cnt", 64'(dut.out_cnt_q), 64'd0);
    rst = 1'b0;
    nxt();
    chk("r_idle_rdy", 64'(xfer_src_req_rdy), 64'd1);
    chk("r_no_done", 64'(xfer_done_val), 64'd0);
    send(8'd4, 16'h3000, 32'd100);
    chunk("r_new", 16'h3000, 16'd100);
    chk("r_new_flow", 64'(chunk_rd_buf_req_flowid), 64'd4);
    nxt();
    chk("r_new_drain", 64'(chunk_rd_buf_req_val), 64'd0);
    mon(1'b1);
    nxt();
    mon(1'b0);
    done("r_new_done", 8'd4);
    nxt();
    chk("r_end_rdy", 64'(xfer_src_req_rdy), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rd_buf_chunk_req.md
Name: rd_buf_chunk_req

Overview:
- Request splitter that sits directly upstream of the NoC-attached read circular buffer tile.
- Accepts one whole-transfer read (flow, start offset, total byte length) and issues it as a sequence of bounded-size chunk requests on the tile's src_rd_buf_req interface.
- Snoops the tile's data return stream to track outstanding chunks.
- Emits a completion token once every byte has been returned.

Parameters:
- BUF_PTR_W, 16: circular-buffer byte offset width. Offsets wrap modulo 2^BUF_PTR_W.
- XFER_SIZE_W, 32: width of the total transfer length.
- MAX_CHUNK, 1024: maximum bytes per chunk request. Power of two, less than 2^`MSG_DATA_SIZE_WIDTH.
- MAX_OUTSTANDING, 4: maximum issued chunks whose last data beat has not yet been returned.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- src_xfer_req_val  in  1  transfer request valid
- src_xfer_req_flowid  in  `FLOW_ID_W  flow id
- src_xfer_req_offset  in  BUF_PTR_W  start byte offset
- src_xfer_req_size  in  XFER_SIZE_W  total bytes
- xfer_src_req_rdy  out  1  transfer request accepted when val&rdy
- chunk_rd_buf_req_val  out  1  chunk request valid (drives src_rd_buf_req_val)
- chunk_rd_buf_req_flowid  out  `FLOW_ID_W  chunk flow id
- chunk_rd_buf_req_offset  out  BUF_PTR_W  chunk start offset
- chunk_rd_buf_req_size  out  `MSG_DATA_SIZE_WIDTH  chunk bytes
- rd_buf_chunk_req_rdy  in  1  tile accepts chunk request
- mon_rd_buf_data_val  in  1  snooped rd_buf_src_data_val
- mon_rd_buf_data_last  in  1  snooped rd_buf_src_data_last
- mon_rd_buf_data_rdy  in  1  snooped src_rd_buf_data_rdy
- xfer_done_val  out  1  transfer complete
- xfer_done_flowid  out  `FLOW_ID_W  completed flow id
- dst_xfer_done_rdy  in  1  done token consumed

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst is synchronous, active-high.
  - Reset state: state=IDLE, outstanding count=0. xfer_src_req_rdy=0 during reset, 1 the cycle after. chunk_rd_buf_req_val=0, xfer_done_val=0. All data outputs 0.
- Registered state: flowid, cur_offset (BUF_PTR_W), remaining (XFER_SIZE_W), out_cnt (clog2(MAX_OUTSTANDING+1)).
- States:
  - IDLE:
    - xfer_src_req_rdy=1.
    - On val&rdy: latch flowid, offset, size.
    - Size==0: go to DONE. No chunk is issued.
    - Otherwise: go to ISSUE.
  - ISSUE:
    - chunk_rd_buf_req_val=1 only while out_cnt<MAX_OUTSTANDING.
    - Chunk size = min(remaining, MAX_CHUNK). Chunk offset = cur_offset.
    - On handshake: cur_offset += chunk size, wrapping mod 2^BUF_PTR_W (carry dropped); remaining -= chunk size; out_cnt += 1.
    - Handshake of the chunk that makes remaining 0: go to DRAIN.
    - Outputs are registers: val stays high and fields stay stable until rdy.
  - DRAIN:
    - No requests issued.
    - When out_cnt==0 (including a decrement landing it at 0 this cycle): go to DONE on the next cycle.
  - DONE:
    - xfer_done_val=1, xfer_done_flowid=latched flowid.
    - Held until dst_xfer_done_rdy. Then go to IDLE.
- Completion tracking:
  - A chunk completes when mon_rd_buf_data_val & mon_rd_buf_data_rdy & mon_rd_buf_data_last.
  - Each completion decrements out_cnt.
  - Issue handshake and completion in the same cycle: out_cnt unchanged.
  - Completion with out_cnt==0 is a protocol error: ignored, counter saturates at 0.
- Latency:
  - Accept to first chunk_rd_buf_req_val: 1 cycle.
  - With rdy held high and no outstanding limit hit: one chunk per cycle.
  - Last completion to xfer_done_val: 1 cycle.
- Wrap-around: a chunk may straddle the buffer end. The tile handles physical wrap; this block only wraps the offset arithmetic.
- Single transfer in flight. A new transfer is not accepted until the done token is consumed.
- Reset mid-transfer: all state is discarded and the block returns to IDLE with out_cnt=0. No done token is produced for the aborted transfer.

Test Plan:
- Basic split: size=2500, offset=0x0100, flowid=3, MAX_CHUNK=1024, rdy always 1, each chunk returned.
  - Required: chunks (0x0100,1024), (0x0500,1024), (0x0900,452).
  - Required: xfer_done_val with flowid=3 exactly 1 cycle after the third last beat.
- Offset wrap: BUF_PTR_W=16, offset=0xFE00, size=2048.
  - Required: chunks (0xFE00,1024), (0x0200,1024).
- Outstanding limit: size=8192, no data returned.
  - Required: exactly 4 chunks issued, then chunk_rd_buf_req_val stays 0.
  - Returning one last beat → exactly one more chunk issued.
  - Also required: an issue handshake and a completion in the same cycle leave out_cnt unchanged.
- Zero size: size=0, flowid=7.
  - Required: no chunk request. xfer_done_val flowid=7 the cycle after accept. xfer_src_req_rdy=0 until done is consumed.
- Backpressure: rd_buf_chunk_req_rdy=0 for 5 cycles, then dst_xfer_done_rdy=0 for 3 cycles.
  - Required: request fields held stable throughout; done token held stable throughout.
- Reset mid-transfer: assert rst during ISSUE after 2 chunks.
  - Required: next cycle all valids 0, out_cnt=0.
  - A following size=100 transfer issues the single chunk (offset, 100) and completes normally.
